// File: rtl/complex_mult_pipe.sv
// Three-stage pipelined complex multiplier (optional conjugate of b) with requantisation.
// Optional sticky saturation flag enabled by macro COMPLEX_MULT_SAT_FLAG_EN.
module complex_mult_pipe #(
    parameter int NB_A       = 17,
    parameter int NBF_A      = 10,
    parameter int NB_B       = 17,
    parameter int NBF_B      = 10,
    parameter int NB_Y       = 17,
    parameter int NBF_Y      = 10,
    parameter int ROUND_EVEN = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic signed [NB_A-1:0] i_aI,
    input  logic signed [NB_A-1:0] i_aQ,
    input  logic signed [NB_B-1:0] i_bI,
    input  logic signed [NB_B-1:0] i_bQ,
    input  logic                   i_conj,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic signed [NB_Y-1:0] o_yI,
    output logic signed [NB_Y-1:0] o_yQ,
    output logic                   o_valid,
    input  logic                   i_ready,
    input  logic                   i_sat_clr,
    output logic                   o_sat_flag
);

    localparam int NP = NB_A + NB_B;
    localparam int NS = NP + 1;
    localparam int D  = NBF_A + NBF_B - NBF_Y;
    localparam int NW = (NS + 1 > NB_Y + 1) ? NS + 1 : NB_Y + 1;

    localparam logic signed [NW-1:0] MAXV = (NW'(1) <<< (NB_Y - 1)) - NW'(1);
    localparam logic signed [NW-1:0] MINV = -(NW'(1) <<< (NB_Y - 1));

    if (NBF_A + NBF_B < NBF_Y) begin : g_cfg_err
        $error("complex_mult_pipe: NBF_A+NBF_B must be >= NBF_Y");
    end

    logic                   w_en;
    logic                   r_v1, r_v2, r_v3;
    logic signed [NB_A-1:0] r_aI, r_aQ;
    logic signed [NB_B-1:0] r_bI, r_bQ;
    logic                   r_conj1, r_conj2;
    logic signed [NP-1:0]   r_p1, r_p2, r_p3, r_p4;
    logic signed [NS-1:0]   w_sumI, w_sumQ;
    logic        [NB_Y:0]   w_qI, w_qQ;
    logic signed [NB_Y-1:0] w_yI, w_yQ;
    logic                   w_clipI, w_clipQ;
    logic signed [NB_Y-1:0] r_yI, r_yQ;

    // Returns {clipped, y}. One guard bit above the sum keeps the rounding bias add overflow-free.
    function automatic logic [NB_Y:0] requant(input logic signed [NS-1:0] s);
        logic signed [NW-1:0] ext;
        logic signed [NW-1:0] half;
        logic signed [NW-1:0] q;
        logic                 clip;
        logic [NB_Y-1:0]      y;
        ext  = NW'(s);
        half = (NW'(1) << D) >>> 1;
        if (D == 0)
            q = ext;
        else if (ROUND_EVEN != 0)
            q = (ext + half - NW'(1) + ((ext >> D) & NW'(1))) >>> D;
        else
            q = ext >>> D;
        if (q > MAXV) begin
            clip = 1'b1;
            y    = MAXV[NB_Y-1:0];
        end else if (q < MINV) begin
            clip = 1'b1;
            y    = MINV[NB_Y-1:0];
        end else begin
            clip = 1'b0;
            y    = q[NB_Y-1:0];
        end
        return {clip, y};
    endfunction

    assign w_en    = !(r_v3 && !i_ready);
    assign o_ready = w_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v1    <= 1'b0;
            r_aI    <= '0;
            r_aQ    <= '0;
            r_bI    <= '0;
            r_bQ    <= '0;
            r_conj1 <= 1'b0;
        end else if (w_en) begin
            r_v1    <= i_valid;
            r_aI    <= i_aI;
            r_aQ    <= i_aQ;
            r_bI    <= i_bI;
            r_bQ    <= i_bQ;
            r_conj1 <= i_conj;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v2    <= 1'b0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_p3    <= '0;
            r_p4    <= '0;
            r_conj2 <= 1'b0;
        end else if (w_en) begin
            r_v2    <= r_v1;
            r_p1    <= NP'(r_aI) * NP'(r_bI);
            r_p2    <= NP'(r_aQ) * NP'(r_bQ);
            r_p3    <= NP'(r_aI) * NP'(r_bQ);
            r_p4    <= NP'(r_aQ) * NP'(r_bI);
            r_conj2 <= r_conj1;
        end
    end

    always_comb begin
        w_sumI = '0;
        w_sumQ = '0;
        if (r_conj2) begin
            w_sumI = NS'(r_p1) + NS'(r_p2);
            w_sumQ = NS'(r_p4) - NS'(r_p3);
        end else begin
            w_sumI = NS'(r_p1) - NS'(r_p2);
            w_sumQ = NS'(r_p3) + NS'(r_p4);
        end
    end

    assign w_qI    = requant(w_sumI);
    assign w_qQ    = requant(w_sumQ);
    assign w_yI    = w_qI[NB_Y-1:0];
    assign w_yQ    = w_qQ[NB_Y-1:0];
    assign w_clipI = w_qI[NB_Y];
    assign w_clipQ = w_qQ[NB_Y];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_v3 <= 1'b0;
            r_yI <= '0;
            r_yQ <= '0;
        end else if (w_en) begin
            r_v3 <= r_v2;
            r_yI <= w_yI;
            r_yQ <= w_yQ;
        end
    end

    assign o_valid = r_v3;
    assign o_yI    = r_yI;
    assign o_yQ    = r_yQ;

`ifdef COMPLEX_MULT_SAT_FLAG_EN
    logic r_sat_flag;

    // Set takes priority over a coincident clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_sat_flag <= 1'b0;
        else if (w_en && r_v2 && (w_clipI || w_clipQ))
            r_sat_flag <= 1'b1;
        else if (i_sat_clr)
            r_sat_flag <= 1'b0;
    end

    assign o_sat_flag = r_sat_flag;
`else
    logic w_unused_sat;
    assign w_unused_sat = ^{i_sat_clr, w_clipI, w_clipQ};
    assign o_sat_flag   = 1'b0;
`endif

endmodule

// File: tb/tb_complex_mult_pipe.sv
// Scoreboard bench for complex_mult_pipe: convergent and floor instances checked side by side.
module tb_complex_mult_pipe;

`ifdef COMPLEX_MULT_SAT_FLAG_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    typedef struct {
        int yI;
        int yQ;
        int fI;
        int fQ;
        bit sat;
    } exp_t;

    logic               i_clk;
    logic               rst_n;
    logic signed [16:0] aI, aQ, bI, bQ;
    logic               conj, in_valid, out_ready, sat_clr;
    logic               o_ready, o_valid, o_sat_flag;
    logic signed [16:0] o_yI, o_yQ;
    logic               f_ready, f_valid, f_sat_flag;
    logic signed [16:0] f_yI, f_yQ;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   m_flag = 0;
    int   stall_cnt = 0;

    complex_mult_pipe #(.NB_A(17), .NBF_A(10), .NB_B(17), .NBF_B(10),
                        .NB_Y(17), .NBF_Y(10), .ROUND_EVEN(1)) u_dut (
        .i_clk(i_clk), .i_rst_n(rst_n),
        .i_aI(aI), .i_aQ(aQ), .i_bI(bI), .i_bQ(bQ),
        .i_conj(conj), .i_valid(in_valid), .o_ready(o_ready),
        .o_yI(o_yI), .o_yQ(o_yQ), .o_valid(o_valid), .i_ready(out_ready),
        .i_sat_clr(sat_clr), .o_sat_flag(o_sat_flag)
    );

    complex_mult_pipe #(.NB_A(17), .NBF_A(10), .NB_B(17), .NBF_B(10),
                        .NB_Y(17), .NBF_Y(10), .ROUND_EVEN(0)) u_flr (
        .i_clk(i_clk), .i_rst_n(rst_n),
        .i_aI(aI), .i_aQ(aQ), .i_bI(bI), .i_bQ(bQ),
        .i_conj(conj), .i_valid(in_valid), .o_ready(f_ready),
        .o_yI(f_yI), .o_yQ(f_yQ), .o_valid(f_valid), .i_ready(out_ready),
        .i_sat_clr(sat_clr), .o_sat_flag(f_sat_flag)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: holds are checked against the queue head, pops happen only on handshake.
    always @(negedge i_clk) begin
        if (rst_n) begin
            chk("o_ready_rule", int'(o_ready), int'(!(o_valid && !out_ready)));
            chk("f_ready_eq", int'(f_ready), int'(o_ready));
            chk("f_valid_eq", int'(f_valid), int'(o_valid));
            if (!o_ready) stall_cnt++;
            if (o_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_valid", int'(o_valid), 0);
                end else begin
                    exp_t e;
                    bit   fexp;
                    e    = q[0];
                    fexp = SAT_ON & (m_flag | e.sat);
                    chk("yI_round", int'(o_yI), e.yI);
                    chk("yQ_round", int'(o_yQ), e.yQ);
                    chk("yI_floor", int'(f_yI), e.fI);
                    chk("yQ_floor", int'(f_yQ), e.fQ);
                    chk("sat_flag", int'(o_sat_flag), int'(fexp));
                    chk("sat_flag_floor", int'(f_sat_flag), int'(fexp));
                    if (out_ready) begin
                        void'(q.pop_front());
                        if (e.sat) m_flag = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send(input int vaI, input int vaQ, input int vbI, input int vbQ, input bit vc,
                        input int yI, input int yQ, input int fI, input int fQ, input bit sat);
        exp_t e;
        bit   acc;
        e.yI = yI; e.yQ = yQ; e.fI = fI; e.fQ = fQ; e.sat = sat;
        aI = vaI[16:0]; aQ = vaQ[16:0]; bI = vbI[16:0]; bQ = vbQ[16:0];
        conj = vc;
        in_valid = 1'b1;
        q.push_back(e);
        acc = 1'b0;
        for (int n = 0; n < 64 && !acc; n++) begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
        end
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 100 && q.size() != 0; n++) begin
            @(posedge i_clk);
            #1;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1; sat_clr = 1'b0; in_valid = 1'b0;
        aI = '0; aQ = '0; bI = '0; bQ = '0; conj = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_o_ready", int'(o_ready), 1);
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_o_yI", int'(o_yI), 0);
        chk("rst_o_yQ", int'(o_yQ), 0);
        chk("rst_sat_flag", int'(o_sat_flag), 0);
        rst_n = 1'b1;
        idle(2);

        // Directed vectors: (aI,aQ,bI,bQ,conj, convergent yI,yQ, floor yI,yQ, clip)
        send(1024, 0, 512, 256, 0,      512, 256,    512, 256, 0);
        send(0, 1024, 0, 1024, 0,     -1024,   0,  -1024,   0, 0);
        send(0, 1024, 0, 1024, 1,      1024,   0,   1024,   0, 0);
        send(1, 0, 512, 0, 0,             0,   0,      0,   0, 0);
        send(3, 0, 512, 0, 0,             2,   0,      1,   0, 0);
        send(-1, 0, 512, 0, 0,            0,   0,     -1,   0, 0);
        send(-3, 0, 512, 0, 0,           -2,   0,     -2,   0, 0);
        send(100, 200, 300, 400, 0,     -49,  98,    -49,  97, 0);
        send(100, 200, 300, 400, 1,     107,  20,    107,  19, 0);
        send(-65536, 0, -65536, 0, 0, 65535,   0,  65535,   0, 1);
        send(-65536, 0, 65535, 0, 0, -65536,   0, -65536,   0, 1);
        send(1024, 0, 512, 256, 0,      512, 256,    512, 256, 0);
        drain();

        idle(5);
        chk("sat_sticky", int'(o_sat_flag), int'(SAT_ON));
        chk("sat_sticky_floor", int'(f_sat_flag), int'(SAT_ON));
        sat_clr = 1'b1;
        @(posedge i_clk);
        #1;
        sat_clr = 1'b0;
        m_flag = 1'b0;
        chk("sat_cleared", int'(o_sat_flag), 0);
        idle(3);

        // Six back-to-back samples; downstream stalls for 4 cycles mid-stream.
        stall_cnt = 0;
        fork
            begin
                repeat (4) @(posedge i_clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge i_clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int n = 1; n <= 6; n++)
            send(1024, 0, n, -n, 0, n, -n, n, -n, 0);
        drain();
        chk("stall_cycles", stall_cnt, 4);
        chk("stream_no_sat", int'(o_sat_flag), 0);

        // Reset with three samples in flight.
        send(1024, 0, 7, 8, 0, 7, 8, 7, 8, 0);
        send(1024, 0, 9, 10, 0, 9, 10, 9, 10, 0);
        send(1024, 0, 11, 12, 0, 11, 12, 11, 12, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_o_valid", int'(o_valid), 0);
        chk("midrst_o_ready", int'(o_ready), 1);
        chk("midrst_o_yI", int'(o_yI), 0);
        @(posedge i_clk);
        #1;
        q.delete();
        m_flag = 1'b0;
        rst_n = 1'b1;
        idle(10);
        chk("postrst_o_valid", int'(o_valid), 0);
        chk("postrst_o_ready", int'(o_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/complex_mult_pipe.md
COMPLEX_MULT_PIPE -- requirements
Module: complex_mult_pipe

Interface
REQ-001 The module SHALL have parameter NB_A, default 17, meaning the total width of operand a.
REQ-002 The module SHALL have parameter NBF_A, default 10, meaning the fractional bits of operand a.
REQ-003 The module SHALL have parameter NB_B, default 17, meaning the total width of operand b.
REQ-004 The module SHALL have parameter NBF_B, default 10, meaning the fractional bits of operand b.
REQ-005 The module SHALL have parameter NB_Y, default 17, meaning the total width of output y.
REQ-006 The module SHALL have parameter NBF_Y, default 10, meaning the fractional bits of output y.
REQ-007 The module SHALL have parameter ROUND_EVEN, default 1: 1 = convergent rounding, 0 = truncate (floor).
REQ-008 The module SHALL have port i_clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-009 The module SHALL have port i_rst_n, input, 1 bit, the asynchronous active-low reset.
REQ-010 The module SHALL have ports i_aI and i_aQ, input, NB_A bits each, signed operand a.
REQ-011 The module SHALL have ports i_bI and i_bQ, input, NB_B bits each, signed operand b.
REQ-012 The module SHALL have port i_conj, input, 1 bit; when 1 the sample computes a*conj(b).
REQ-013 The module SHALL have port i_valid, input, 1 bit, input sample valid.
REQ-014 The module SHALL have port o_ready, output, 1 bit, input accepted when i_valid && o_ready.
REQ-015 The module SHALL have ports o_yI and o_yQ, output, NB_Y bits each, signed product.
REQ-016 The module SHALL have port o_valid, output, 1 bit, output sample valid.
REQ-017 The module SHALL have port i_ready, input, 1 bit, downstream ready.
REQ-018 The module SHALL have port i_sat_clr, input, 1 bit, synchronous clear of the sticky saturation flag.
REQ-019 The module SHALL have port o_sat_flag, output, 1 bit, sticky saturation indicator.

Function
REQ-020 The datapath SHALL be a 3-stage pipeline: S1 registers inputs and i_conj; S2 registers the four products aI*bI, aQ*bQ, aI*bQ, aQ*bI (NB_A+NB_B bits each); S3 registers the rounded and saturated result.
REQ-021 The adder SHALL be NB_A+NB_B+1 bits with NBF_A+NBF_B fractional bits: yI = p1 - p2 and yQ = p3 + p4 when conj=0; yI = p1 + p2 and yQ = p4 - p3 when conj=1.
REQ-022 Requantisation SHALL drop NBF_A+NBF_B-NBF_Y LSBs (round-half-to-even or floor per ROUND_EVEN), then saturate to [-2^(NB_Y-1), 2^(NB_Y-1)-1].
REQ-023 Elaboration SHALL fail if NBF_A+NBF_B < NBF_Y.
REQ-024 Latency SHALL be exactly 3 clock cycles from input acceptance to o_valid with no stall.
REQ-025 The global enable SHALL be en = !(o_valid && !i_ready); o_ready = en, combinational.
REQ-026 When en=0 all stage registers and valid bits SHALL hold; bubbles SHALL NOT be compressed.
REQ-027 Valid bits SHALL propagate one stage per enabled cycle; a stage with valid=0 SHALL carry don't-care data.
REQ-028 o_yI/o_yQ SHALL remain stable while o_valid && !i_ready.

Reset
REQ-029 Asserting i_rst_n=0 SHALL asynchronously clear all valid bits, o_yI, o_yQ and o_sat_flag to 0; data registers SHALL also be cleared to 0.
REQ-030 Samples in flight at reset SHALL be discarded; o_ready SHALL be 1 during and after reset.

Configuration
REQ-031 With macro COMPLEX_MULT_SAT_FLAG_EN defined, o_sat_flag SHALL set on any cycle where S3 loads a valid sample whose I or Q result clipped; on simultaneous set and i_sat_clr, set SHALL win.
REQ-032 Without COMPLEX_MULT_SAT_FLAG_EN, o_sat_flag SHALL be tied 0 and i_sat_clr SHALL be ignored; the datapath SHALL be unchanged.

Verification (defaults, i_ready=1 unless stated)
REQ-033 a=(1024,0), b=(512,256), conj=0 -> o_valid 3 cycles later with y=(512,256).
REQ-034 a=(0,1024), b=(0,1024): conj=0 -> y=(-1024,0); conj=1 -> y=(1024,0).
REQ-035 a=(-65536,0), b=(-65536,0) -> y=(65535,0); o_sat_flag=1 (macro on), remains 1 until i_sat_clr, and stays 0 with macro off.
REQ-036 ROUND_EVEN=1: a=(1,0), b=(512,0) -> yI=0 and a=(3,0), b=(512,0) -> yI=2; ROUND_EVEN=0: the same inputs -> yI=0 and yI=1.
REQ-037 Stream 6 back-to-back samples with i_ready low for 4 cycles mid-stream -> o_ready=0 while stalled, outputs held, all 6 results emitted in order, none lost or duplicated.
REQ-038 Drop i_rst_n for 1 cycle with 3 samples in flight -> o_valid=0 immediately, no stale output after release.
